// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: start/done handshake, target-LUT write port,
// decoder branch/halt controls and the PC/status outputs.
interface fetch_ctrl_if #(
  parameter int unsigned D     = 12,
  parameter int unsigned LUT_W = 4,
  parameter int unsigned OFS_W = 8
);
  logic             start;
  logic [D-1:0]     start_addr;
  logic             lut_we;
  logic [LUT_W-1:0] lut_waddr;
  logic [D-1:0]     lut_wdata;
  logic             abs_br;
  logic [LUT_W-1:0] lut_idx;
  logic             rel_br;
  logic [OFS_W-1:0] offset;
  logic             stall;
  logic             halt;
  logic [D-1:0]     prog_ctr;
  logic             busy;
  logic             done;
  logic [15:0]      cycle_cnt;

  modport master (
    output start, start_addr, lut_we, lut_waddr, lut_wdata,
           abs_br, lut_idx, rel_br, offset, stall, halt,
    input  prog_ctr, busy, done, cycle_cnt
  );

  modport slave (
    input  start, start_addr, lut_we, lut_waddr, lut_wdata,
           abs_br, lut_idx, rel_br, offset, stall, halt,
    output prog_ctr, busy, done, cycle_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Program-counter / fetch sequencer: steps the PC, redirects on absolute
// (LUT) or relative branches, and counts cycles spent executing.
module fetch_ctrl #(
  parameter int unsigned D     = 12,
  parameter int unsigned LUT_W = 4,
  parameter int unsigned OFS_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.slave  bus
);
  localparam int unsigned N_LUT = 2 ** LUT_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [D-1:0] lut_q [N_LUT];
  logic [D-1:0] lut_d [N_LUT];
  logic [D-1:0] ofs_sext;

  assign ofs_sext = {{(D-OFS_W){bus.offset[OFS_W-1]}}, bus.offset};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    lut_d   = lut_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.lut_we) lut_d[bus.lut_waddr] = bus.lut_wdata;
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        // Priority: halt > stall > abs_br > rel_br > sequential step.
        if (bus.halt)        state_d = DONE;
        else if (bus.stall)  pc_d = pc_q;
        else if (bus.abs_br) pc_d = lut_q[bus.lut_idx];
        else if (bus.rel_br) pc_d = pc_q + ofs_sext;
        else                 pc_d = pc_q + D'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lut_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lut_q   <= lut_d;
    end
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;
  localparam int unsigned D     = 12;
  localparam int unsigned LUT_W = 4;
  localparam int unsigned OFS_W = 8;
  localparam int PC_MOD = 1 << D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.D(D), .LUT_W(LUT_W), .OFS_W(OFS_W)) bus ();

  fetch_ctrl #(.D(D), .LUT_W(LUT_W), .OFS_W(OFS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit m_running;
  bit m_finished;
  int m_pc;
  int m_cnt;
  int m_lut [16];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_running = 0; m_finished = 0; m_pc = 0; m_cnt = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic clr_inputs();
    bus.start = 0; bus.start_addr = '0; bus.lut_we = 0; bus.lut_waddr = '0;
    bus.lut_wdata = '0; bus.abs_br = 0; bus.lut_idx = '0; bus.rel_br = 0;
    bus.offset = '0; bus.stall = 0; bus.halt = 0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    if (!m_running) begin
      if (bus.lut_we) m_lut[int'(bus.lut_waddr)] = int'(bus.lut_wdata);
      if (bus.start) begin
        m_running = 1; m_finished = 0;
        m_pc = int'(bus.start_addr); m_cnt = 0;
      end
    end else begin
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (bus.halt) begin
        m_running = 0; m_finished = 1;
      end else if (bus.stall) begin
        m_pc = m_pc;
      end else if (bus.abs_br) begin
        m_pc = m_lut[int'(bus.lut_idx)];
      end else if (bus.rel_br) begin
        m_pc = (m_pc + int'($signed(bus.offset))) & (PC_MOD - 1);
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pc"},   int'(bus.prog_ctr),  m_pc);
    check({tag, "_busy"}, int'(bus.busy),      int'(m_running));
    check({tag, "_done"}, int'(bus.done),      int'(m_finished));
    check({tag, "_cnt"},  int'(bus.cycle_cnt), m_cnt);
  endtask

  // One clock edge: update model, wait edge, sample 1 time unit later.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
    clr_inputs();
  endtask

  task automatic do_start(input int addr);
    bus.start = 1; bus.start_addr = D'(addr);
    step("start");
  endtask

  task automatic do_halt();
    bus.halt = 1;
    step("halt");
  endtask

  initial begin
    clr_inputs();
    model_reset();
    #12;
    compare_all("reset");
    check("reset_pc_const", int'(bus.prog_ctr), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // LUT write in IDLE, then straight-line execution from 0
    bus.lut_we = 1; bus.lut_waddr = 4'd3; bus.lut_wdata = 12'h1A0;
    step("lutw");
    do_start(0);
    check("start_busy", int'(bus.busy), 1);
    for (int i = 0; i < 5; i++) step("seq");
    check("seq_pc5", int'(bus.prog_ctr), 5);
    check("seq_cnt5", int'(bus.cycle_cnt), 5);
    do_halt();

    // Absolute branch with simultaneous rel_br at PC=2
    do_start(0);
    step("seq"); step("seq");
    bus.abs_br = 1; bus.lut_idx = 4'd3; bus.rel_br = 1; bus.offset = 8'h05;
    step("absbr");
    check("absbr_pc", int'(bus.prog_ctr), 12'h1A0);
    do_halt();

    // Relative branch wrapping below zero, then sequential wrap at FFF
    do_start(5);
    bus.rel_br = 1; bus.offset = 8'hF6;
    step("relbr");
    check("relwrap_pc", int'(bus.prog_ctr), 12'hFFB);
    for (int i = 0; i < 4; i++) step("seq");
    check("pc_fff", int'(bus.prog_ctr), 12'hFFF);
    step("seq");
    check("seqwrap_pc", int'(bus.prog_ctr), 0);
    do_halt();

    // Stall holds PC; halt overrides stall; counter freezes in DONE
    do_start(7);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1;
      step("stall");
    end
    check("stall_pc", int'(bus.prog_ctr), 7);
    check("stall_cnt", int'(bus.cycle_cnt), 3);
    bus.stall = 1; bus.halt = 1;
    step("halt_stall");
    check("halt_done", int'(bus.done), 1);
    check("halt_pc", int'(bus.prog_ctr), 7);
    check("halt_cnt", int'(bus.cycle_cnt), 4);
    step("done_idle");
    check("done_cnt_frozen", int'(bus.cycle_cnt), 4);

    // LUT write and start on the same edge from DONE
    bus.lut_we = 1; bus.lut_waddr = 4'd0; bus.lut_wdata = 12'h055;
    bus.start = 1; bus.start_addr = 12'h100;
    step("restart");
    check("restart_pc", int'(bus.prog_ctr), 12'h100);
    check("restart_done", int'(bus.done), 0);
    check("restart_cnt", int'(bus.cycle_cnt), 0);
    bus.lut_we = 1; bus.lut_waddr = 4'd0; bus.lut_wdata = 12'h0AA;
    bus.start = 1; bus.start_addr = 12'h200;
    step("run_lutw_ignored");
    check("run_start_ignored", int'(bus.prog_ctr), 12'h101);
    bus.abs_br = 1; bus.lut_idx = 4'd0;
    step("lut_kept");
    check("lut_kept_pc", int'(bus.prog_ctr), 12'h055);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.start      = ($urandom_range(0, 5) == 0);
      bus.start_addr = D'($urandom);
      bus.lut_we     = ($urandom_range(0, 3) == 0);
      bus.lut_waddr  = LUT_W'($urandom);
      bus.lut_wdata  = D'($urandom);
      bus.halt       = ($urandom_range(0, 24) == 0);
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.abs_br     = ($urandom_range(0, 5) == 0);
      bus.lut_idx    = LUT_W'($urandom);
      bus.rel_br     = ($urandom_range(0, 3) == 0);
      bus.offset     = OFS_W'($urandom);
      step("rand");
    end

    // Asynchronous reset between edges while running
    if (!m_running) do_start(12'h300);
    do_start(12'h300);
    step("pre_rst");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    compare_all("post_rst_idle");
    check("post_rst_busy", int'(bus.busy), 0);
    do_start(0);
    bus.abs_br = 1; bus.lut_idx = 4'd3;
    step("lut_cleared");
    check("lut_cleared_pc", int'(bus.prog_ctr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch sequencer that drives `prog_ctr` into the instruction ROM and consumes branch/halt controls from the decoder. It holds the registered PC, steps it each cycle, and redirects it on absolute branches through a small loadable target lookup table or on signed relative branches. It runs a start/done handshake with the testbench or top level and counts executed cycles.

## Interface
- `D`, 12: PC width; must match the instruction ROM address width.
- `LUT_W`, 4: target-LUT index width, giving 2**LUT_W entries of D bits each.
- `OFS_W`, 8: relative branch offset width, two's complement.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution at `start_addr`; honoured only in IDLE or DONE.
- `start_addr`  in  D  first PC after `start`.
- `lut_we`  in  1  target-LUT write enable; honoured only in IDLE or DONE.
- `lut_waddr`  in  LUT_W  LUT write index.
- `lut_wdata`  in  D  LUT write data.
- `abs_br`  in  1  absolute branch: the next PC is `lut[lut_idx]`.
- `lut_idx`  in  LUT_W  LUT read index for `abs_br`.
- `rel_br`  in  1  relative branch: the next PC is PC + sign-extended `offset`.
- `offset`  in  OFS_W  signed relative offset.
- `stall`  in  1  hold the PC this cycle.
- `halt`  in  1  the current instruction is the program's last.
- `prog_ctr`  out  D  registered PC driven to the instruction ROM.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `cycle_cnt`  out  16  number of clock edges spent in RUN since the last `start`.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `prog_ctr`=0, `busy`=0, `done`=0, `cycle_cnt`=0, all LUT entries 0.
- IDLE → RUN on `start`: `prog_ctr` ← `start_addr`, `cycle_cnt` ← 0.
- DONE → RUN on `start`: same actions as from IDLE. `done` stays high until the `start` edge.
- In RUN, per edge, first match wins:
  - `halt`: go to DONE; `prog_ctr` holds the halting address.
  - `stall`: `prog_ctr` holds.
  - `abs_br`: `prog_ctr` ← `lut[lut_idx]`.
  - `rel_br`: `prog_ctr` ← (`prog_ctr` + sext(`offset`)) mod 2**D.
  - otherwise: `prog_ctr` ← (`prog_ctr` + 1) mod 2**D; 2**D−1 wraps to 0.
- `halt` overrides `stall`: a stalled halting instruction still finishes.
- `abs_br` and `rel_br` together: `abs_br` wins and `rel_br` is ignored.
- `start` during RUN is ignored, with no restart.
- `cycle_cnt` increments on every RUN edge, including stall edges and the halting edge.
  - It saturates at 16'hFFFF.
  - It is frozen in IDLE and DONE, and cleared only by reset or an accepted `start`.
- LUT writes:
  - Honoured in IDLE and DONE; ignored in RUN.
  - A write and `start` in the same edge both take effect.
- LUT reads are combinational from the register array.
- Asserting `rst_n` low mid-RUN immediately forces the reset values, independent of `clk`. Execution resumes only after a new `start`.

## Timing
- `prog_ctr` is a register. The ROM output for it is valid combinationally in the same cycle, and the decoder's `abs_br`/`rel_br`/`stall`/`halt` are sampled at the next rising edge.
- Branch latency is one edge, with no delay slot: the instruction at the target is presented in the cycle after the branch instruction.
- From the `start` edge, `prog_ctr`=`start_addr` and `busy`=1 hold for the following cycle.
- From the `halt` edge, `busy`=0 and `done`=1 hold for the following cycle.
- Control inputs are don't-care in IDLE and DONE; only `start` and the LUT write port act there.

## Test plan
- Reset, then `start` with `start_addr`=0 and no branches for 5 edges: `prog_ctr` steps 0,1,2,3,4,5; `cycle_cnt`=5; `busy`=1.
- Write `lut[3]`=12'h1A0 in IDLE, then `start`, then `abs_br`=1 with `lut_idx`=3 while PC=2: the next PC is 12'h1A0. Also raise `rel_br` in the same cycle: PC is still 12'h1A0.
- Relative wrap:
  - At PC=12'h005 with `offset`=8'hF6 (−10): the next PC is 12'hFFB.
  - At PC=12'hFFF with no branch: the next PC is 12'h000.
- `stall` for 3 edges at PC=7: the PC holds at 7 and `cycle_cnt` advances by 3. Then `halt` with `stall`=1: DONE, `done`=1, PC=7, `cycle_cnt` frozen.
- In DONE:
  - Write `lut[0]`=12'h055, then `start` with `start_addr`=12'h100: RUN, PC=12'h100, `done`=0, `cycle_cnt`=0.
  - An `lut_we` during RUN leaves the LUT unchanged.
- Pull `rst_n` low between clock edges mid-RUN: outputs go to 0 immediately, the LUT is cleared, and `start` is required to resume.
